spwm_gate_gen: RTL and testbench

SPWM_GATE_GEN -- requirements
Module: spwm_gate_gen

---
 rtl/spwm_gate_gen.sv | 135 +++++++++++++
 tb/tb_spwm_gate_gen.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/spwm_gate_gen.sv
// Sine-PWM gate generator for a full H-bridge.
// A triangle carrier is compared against a half-sine amplitude supplied by an
// external lookup stage; the resulting command steers one leg per half cycle,
// and each leg has its own dead-band timer so that its high-side and low-side
// gates are never driven together.
module spwm_gate_gen #(
  parameter int CARRIER_MAX = 5000,
  parameter int IDX_MAX     = 88,
  parameter int DEAD_TIME   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [12:0] sine_in,
  output logic [6:0]  teth_ta,
  output logic        half,
  output logic        gate_ah,
  output logic        gate_al,
  output logic        gate_bh,
  output logic        gate_bl,
  output logic        period_done
);

  localparam int              DT_W    = (DEAD_TIME < 1) ? 1 : $clog2(DEAD_TIME + 1);
  localparam logic [12:0]     CAR_TOP = 13'(CARRIER_MAX);
  localparam logic [6:0]      IDX_TOP = 7'(IDX_MAX);
  localparam logic [DT_W-1:0] DT_LOAD = DT_W'(DEAD_TIME);
  localparam logic [DT_W-1:0] DT_ONE  = DT_W'(1);

  logic [12:0]     car;
  logic            dir_down;
  logic            idle;

  // stage 0: combinational compare and leg steering
  logic            pwm_p0;
  logic            cmd_a_p0;
  logic            cmd_b_p0;
  logic [DT_W-1:0] cnt_a_nxt_p0;
  logic [DT_W-1:0] cnt_b_nxt_p0;

  // stage 1: registered command history and dead-band counters
  logic            cmd_a_p1;
  logic            cmd_b_p1;
  logic [DT_W-1:0] cnt_a_p1;
  logic [DT_W-1:0] cnt_b_p1;

  // Dead-band counter update: any command change restarts the full dead band,
  // otherwise count down to zero and stay there.
  function automatic logic [DT_W-1:0] dead_next(input logic            cmd,
                                                input logic            prev,
                                                input logic [DT_W-1:0] cnt);
    logic [DT_W-1:0] nxt;
    nxt = '0;
    if (cmd != prev) begin
      nxt = DT_LOAD;
    end else if (cnt != '0) begin
      nxt = cnt - DT_ONE;
    end
    return nxt;
  endfunction

  assign idle = rst | ~en;

  // Carrier compare, half-cycle steering and next dead-band counts.
  always_comb begin
    pwm_p0       = (sine_in > car);
    cmd_a_p0     = pwm_p0 & ~half;
    cmd_b_p0     = pwm_p0 & half;
    cnt_a_nxt_p0 = dead_next(cmd_a_p0, cmd_a_p1, cnt_a_p1);
    cnt_b_nxt_p0 = dead_next(cmd_b_p0, cmd_b_p1, cnt_b_p1);
  end

  // Triangle carrier, table index, polarity and end-of-period pulse.
  always_ff @(posedge clk) begin
    if (idle) begin
      car         <= '0;
      dir_down    <= 1'b0;
      teth_ta     <= '0;
      half        <= 1'b0;
      period_done <= 1'b0;
    end else begin
      period_done <= 1'b0;
      if (!dir_down) begin
        car <= car + 13'd1;
        if (car == CAR_TOP - 13'd1) begin
          dir_down <= 1'b1;
        end
      end else begin
        car <= car - 13'd1;
        if (car == 13'd1) begin
          // valley reached: advance the sine table, wrap at the half-cycle end
          dir_down <= 1'b0;
          if (teth_ta == IDX_TOP) begin
            teth_ta     <= '0;
            half        <= ~half;
            period_done <= half;
          end else begin
            teth_ta <= teth_ta + 7'd1;
          end
        end
      end
    end
  end

  // Leg A: gates follow the command only once its dead band has expired.
  always_ff @(posedge clk) begin
    if (idle) begin
      cmd_a_p1 <= 1'b0;
      cnt_a_p1 <= DT_LOAD;
      gate_ah  <= 1'b0;
      gate_al  <= 1'b0;
    end else begin
      cmd_a_p1 <= cmd_a_p0;
      cnt_a_p1 <= cnt_a_nxt_p0;
      gate_ah  <= (cnt_a_nxt_p0 == '0) & cmd_a_p0;
      gate_al  <= (cnt_a_nxt_p0 == '0) & ~cmd_a_p0;
    end
  end

  // Leg B: same dead-band behaviour with its own counter.
  always_ff @(posedge clk) begin
    if (idle) begin
      cmd_b_p1 <= 1'b0;
      cnt_b_p1 <= DT_LOAD;
      gate_bh  <= 1'b0;
      gate_bl  <= 1'b0;
    end else begin
      cmd_b_p1 <= cmd_b_p0;
      cnt_b_p1 <= cnt_b_nxt_p0;
      gate_bh  <= (cnt_b_nxt_p0 == '0) & cmd_b_p0;
      gate_bl  <= (cnt_b_nxt_p0 == '0) & ~cmd_b_p0;
    end
  end

endmodule

// File: tb/tb_spwm_gate_gen.sv
// Scoreboard bench for spwm_gate_gen with a phase-count reference model.
module tb_spwm_gate_gen;

  localparam int CM = 10;
  localparam int IM = 88;
  localparam int DT = 2;
  localparam real PI = 3.14159265358979;

  logic        clk;
  logic        rst;
  logic        en;
  logic [12:0] sine_in;
  logic [6:0]  teth_ta;
  logic        half;
  logic        gate_ah, gate_al, gate_bh, gate_bl;
  logic        period_done;

  spwm_gate_gen #(.CARRIER_MAX(CM), .IDX_MAX(IM), .DEAD_TIME(DT)) dut (
    .clk(clk), .rst(rst), .en(en), .sine_in(sine_in),
    .teth_ta(teth_ta), .half(half),
    .gate_ah(gate_ah), .gate_al(gate_al), .gate_bh(gate_bh), .gate_bl(gate_bl),
    .period_done(period_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int teth;
    int half;
    int ah, al, bh, bl;
    int pd;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passes = 0;

  // reference model state
  int m;          // active edges since last idle
  int la, lb;     // length of constant-command run per leg (idle counts as a 0 sample)
  int pa, pb;     // last command per leg
  int vis_teth;   // index visible in the current cycle
  int mode;       // 0 table lookup, 1 forced value, 2 random
  int force_val;
  logic [12:0] tab [0:IM];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic int car_of(input int mm);
    int p;
    p = mm % (2 * CM);
    return (p <= CM) ? p : 2 * CM - p;
  endfunction

  // One clock edge of the reference behaviour, from the inputs present at that edge.
  task automatic model_step(input logic r, input logic e, input int s, output exp_t x);
    int ca, cb, pwm, h;
    if (r || !e) begin
      m = 0; la = 1; lb = 1; pa = 0; pb = 0;
      x.teth = 0; x.half = 0; x.ah = 0; x.al = 0; x.bh = 0; x.bl = 0; x.pd = 0;
    end else begin
      h   = (m / (2 * CM * (IM + 1))) % 2;
      pwm = (s > car_of(m)) ? 1 : 0;
      ca  = h ? 0 : pwm;
      cb  = h ? pwm : 0;
      la  = (ca == pa) ? la + 1 : 1;
      lb  = (cb == pb) ? lb + 1 : 1;
      pa  = ca;
      pb  = cb;
      m++;
      x.teth = (m / (2 * CM)) % (IM + 1);
      x.half = (m / (2 * CM * (IM + 1))) % 2;
      x.pd   = (m % (4 * CM * (IM + 1)) == 0) ? 1 : 0;
      x.ah   = (la >= DT + 1 && ca == 1) ? 1 : 0;
      x.al   = (la >= DT + 1 && ca == 0) ? 1 : 0;
      x.bh   = (lb >= DT + 1 && cb == 1) ? 1 : 0;
      x.bl   = (lb >= DT + 1 && cb == 0) ? 1 : 0;
    end
  endtask

  // Advance one clock: predict, queue the expectation, then update the lookup stage.
  task automatic cycle();
    exp_t x;
    int   last;
    @(posedge clk);
    model_step(rst, en, int'(sine_in), x);
    q.push_back(x);
    #1;
    last     = vis_teth;
    vis_teth = x.teth;
    case (mode)
      0:       sine_in = tab[last];
      1:       sine_in = 13'(force_val);
      default: sine_in = ($urandom_range(0, 15) == 0) ? 13'h1fff : 13'($urandom_range(0, 12));
    endcase
  endtask

  task automatic count_win(input int n, output int ah, output int al, output int bh, output int bl);
    ah = 0; al = 0; bh = 0; bl = 0;
    for (int i = 0; i < n; i++) begin
      cycle();
      @(negedge clk);
      ah += int'(gate_ah); al += int'(gate_al);
      bh += int'(gate_bh); bl += int'(gate_bl);
    end
  endtask

  // Monitor: compare each registered output set against the queued expectation.
  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("overlap_a", int'(gate_ah & gate_al), 0);
      chk("overlap_b", int'(gate_bh & gate_bl), 0);
      chk("teth_ta", int'(teth_ta), x.teth);
      chk("half", int'(half), x.half);
      chk("gate_ah", int'(gate_ah), x.ah);
      chk("gate_al", int'(gate_al), x.al);
      chk("gate_bh", int'(gate_bh), x.bh);
      chk("gate_bl", int'(gate_bl), x.bl);
      chk("period_done", int'(period_done), x.pd);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int ah, al, bh, bl, npd;
    for (int i = 0; i <= IM; i++) tab[i] = 13'($rtoi(CM * $sin(PI * i / IM) + 0.5));
    m = 0; la = 1; lb = 1; pa = 0; pb = 0; vis_teth = 0;
    mode = 1; force_val = 5;
    rst = 1'b1; en = 1'b1; sine_in = 13'd5;

    // reset held with en high, then forced amplitude 5 in the positive half
    repeat (3) cycle();
    rst = 1'b0;
    repeat (40) cycle();
    count_win(20, ah, al, bh, bl);
    chk("pos_half_ah_count", ah, 7);
    chk("pos_half_al_count", al, 9);
    chk("pos_half_bh_count", bh, 0);
    chk("pos_half_bl_count", bl, 20);

    // run across the half switch and confirm the legs swap roles
    repeat (1800) cycle();
    count_win(20, ah, al, bh, bl);
    chk("neg_half_ah_count", ah, 0);
    chk("neg_half_al_count", al, 20);
    chk("neg_half_bh_count", bh, 7);
    chk("neg_half_bl_count", bl, 9);

    // minimum amplitude: high side never fires, low side drops around valleys
    rst = 1'b1; force_val = 1;
    cycle();
    rst = 1'b0;
    repeat (40) cycle();
    count_win(40, ah, al, bh, bl);
    chk("min_amp_ah_count", ah, 0);
    chk("min_amp_al_count", al, 34);

    // enable dropped mid-period, then restored
    force_val = 5;
    repeat (27) cycle();
    en = 1'b0;
    repeat (5) cycle();
    en = 1'b1;
    repeat (60) cycle();

    // table-driven free run over two full sine periods
    mode = 0; rst = 1'b1;
    cycle();
    rst = 1'b0;
    npd = 0;
    for (int i = 0; i < 4 * CM * (IM + 1) * 2; i++) begin
      cycle();
      @(negedge clk);
      npd += int'(period_done);
    end
    chk("period_done_pulses", npd, 2);

    // randomized amplitudes with sporadic enable drops and resets
    mode = 2;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
    end
    en = 1'b1; rst = 1'b0;
    repeat (3) cycle();

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    if (q.size() != 0) chk("scoreboard_drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
